demux_1_to_8_capture: RTL and testbench
=======================================

Name: demux_1_to_8_capture

Overview:
- Receiving end of the 8-to-1 bit-select path. A single data bit arrives with a 3-bit select. The block steers the bit into the selected position of an 8-bit capture register.
- It tracks which positions have been written and publishes the reassembled byte once all 8 positions are filled.
- It supports sel-order checking and a partial-frame timeout. It sits downstream of any parallel-to-serial source that sweeps sel 0..7.

Parameters:
- IN_ORDER, 0, 1 = positions must arrive in strict order 0,1,..,7; 0 = any order.
- TIMEOUT, 16, idle cycles allowed between accepted bits of a partial frame before abort; range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in  input  1  data bit to be steered.
- sel  input  3  destination bit position.
- valid  input  1  in/sel are valid this cycle.
- out  output  8  live capture register; bit sel updated on each accepted beat.
- written  output  8  mask of positions written in the current frame.
- frame_word  output  8  last completed byte; held until the next completion.
- frame_done  output  1  one-cycle pulse on frame completion.
- err_dup  output  1  one-cycle pulse: position already written in this frame (IN_ORDER=0), or sel != expected index (IN_ORDER=1).
- timeout  output  1  one-cycle pulse: partial frame aborted.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out=0, written=0, frame_word=0.
  - frame_done=0, err_dup=0, timeout=0.
  - idle counter=0, expected index=0, state=IDLE.
  - Reset mid-frame discards the partial frame with no pulse.
- States:
  - IDLE: written==0.
  - FILL: 1..7 positions written.
  - Completion is not a held state; it is handled within one cycle.
- Accepted beat (valid=1 with no error condition):
  - Next edge: out[sel]<=in, written[sel]<=1, idle counter<=0.
  - IDLE->FILL on the first accepted beat.
- Completion: the accepted beat makes written all-ones.
  - Same edge: frame_word <= out with bit sel replaced by in; frame_done<=1.
  - written<=0, expected index<=0, state->IDLE.
  - out keeps its value. Latency from the last bit to frame_done/frame_word valid is 1 cycle.
- Duplicate (IN_ORDER=0, valid=1, written[sel]=1):
  - The beat is rejected: out and written unchanged, err_dup=1 for one cycle.
  - The frame continues and the idle counter resets.
- Order error (IN_ORDER=1, valid=1, sel != expected index):
  - Beat rejected, err_dup=1, frame aborted: written<=0, expected<=0, state->IDLE.
  - On an accepted beat, expected<=expected+1, wrapping 7->0 at completion.
- Timeout (FILL only):
  - The counter increments on each cycle with valid=0.
  - When the counter reaches TIMEOUT-1 and valid=0: timeout=1, written<=0, counter<=0, state->IDLE. out is not cleared.
  - The counter never runs in IDLE.
  - valid=1 on the would-be timeout cycle takes precedence; no timeout.
- Pulses:
  - frame_done, err_dup and timeout deassert the cycle after assertion unless retriggered.
  - frame_done and err_dup are never both set by the same beat.
- Back-to-back frames: a beat on the cycle after completion starts a new frame. No dead cycle is required.
- X on in/sel while valid=0 has no effect.

Test Plan:
1. Reset, then IN_ORDER=0, in pattern 8'b11010101 LSB-first, sel=0..7 on consecutive cycles -> frame_done pulses exactly 1 cycle after the sel=7 beat; frame_word=8'hD5; written=0 afterwards.
2. IN_ORDER=0, sel order 7,0,3,5,1,6,2,4 with bits taken from 8'hA3 -> frame_word=8'hA3. Then repeat sel=3 mid-frame -> err_dup one pulse, written unchanged, frame still completes.
3. IN_ORDER=1, sel=0,1,3 -> err_dup on the sel=3 beat and written=0. Restart 0..7 with 8'h5A -> frame_word=8'h5A.
4. TIMEOUT=4: write sel=0,1, then hold valid=0 -> timeout pulses on the 4th idle cycle, written 8'h03->0. valid=1 on the 4th idle cycle instead -> no timeout.
5. Assert rst after 5 accepted beats -> all outputs 0 next cycle, no pulses. A full 0..7 sweep then completes normally.
6. Two frames back-to-back (8'hFF then 8'h00, 16 consecutive valid cycles) -> two frame_done pulses 8 cycles apart; frame_word FF then 00.

Source files
------------

// File: rtl/demux_1_to_8_capture.sv
// Steers a serial bit into a selected position of an 8-bit capture register and
// publishes the reassembled byte once every position of the frame has been written.
module demux_1_to_8_capture #(
  parameter bit IN_ORDER = 1'b0,
  parameter int TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  input  logic [2:0] sel,
  input  logic       valid,
  output logic [7:0] out,
  output logic [7:0] written,
  output logic [7:0] frame_word,
  output logic       frame_done,
  output logic       err_dup,
  output logic       timeout,
  output logic       state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] exp_q, exp_d;
  logic [7:0] out_d, written_d, word_d;
  logic       done_d, dup_d, to_d;
  logic       bad_beat;

  assign state_dbg = state_q;

  // A beat is refused when it breaks ordering (strict mode) or repeats a position.
  assign bad_beat = IN_ORDER ? (sel != exp_q) : written[sel];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    out_d     = out;
    written_d = written;
    word_d    = frame_word;
    done_d    = 1'b0;
    dup_d     = 1'b0;
    to_d      = 1'b0;
    if (valid) begin
      cnt_d = 8'd0;
      if (bad_beat) begin
        dup_d = 1'b1;
        if (IN_ORDER) begin
          written_d = 8'd0;
          exp_d     = 3'd0;
          state_d   = IDLE;
        end
      end else begin
        out_d[sel]     = in;
        written_d[sel] = 1'b1;
        exp_d          = exp_q + 3'd1;
        state_d        = FILL;
        // Completion is folded into the accepting edge so a new frame may follow at once.
        if (&written_d) begin
          word_d    = out_d;
          done_d    = 1'b1;
          written_d = 8'd0;
          exp_d     = 3'd0;
          state_d   = IDLE;
        end
      end
    end else if (state_q == FILL) begin
      if (cnt_q == IDLE_LAST) begin
        to_d      = 1'b1;
        written_d = 8'd0;
        cnt_d     = 8'd0;
        exp_d     = 3'd0;
        state_d   = IDLE;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      exp_q      <= 3'd0;
      out        <= 8'd0;
      written    <= 8'd0;
      frame_word <= 8'd0;
      frame_done <= 1'b0;
      err_dup    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      out        <= out_d;
      written    <= written_d;
      frame_word <= word_d;
      frame_done <= done_d;
      err_dup    <= dup_d;
      timeout    <= to_d;
    end
  end

endmodule

// File: tb/tb_demux_1_to_8_capture.sv
// Bench for demux_1_to_8_capture: an any-order instance (TIMEOUT=4) and a strict-order
// instance (TIMEOUT=16) share one stimulus stream; each has its own reference model.
module tb_demux_1_to_8_capture;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in = 1'b0;
  logic [2:0] sel = 3'd0;
  logic       valid = 1'b0;

  logic [7:0] out_a, written_a, word_a, out_b, written_b, word_b;
  logic       done_a, dup_a, to_a, st_a, done_b, dup_b, to_b, st_b;

  demux_1_to_8_capture #(.IN_ORDER(1'b0), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst), .in(in), .sel(sel), .valid(valid),
    .out(out_a), .written(written_a), .frame_word(word_a),
    .frame_done(done_a), .err_dup(dup_a), .timeout(to_a), .state_dbg(st_a)
  );

  demux_1_to_8_capture #(.IN_ORDER(1'b1), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .in(in), .sel(sel), .valid(valid),
    .out(out_b), .written(written_b), .frame_word(word_b),
    .frame_done(done_b), .err_dup(dup_b), .timeout(to_b), .state_dbg(st_b)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame kept as a set of filled positions plus a fill count; strict mode expects the
  // next position to equal the number already filled.
  typedef struct packed {
    logic [7:0] bits;
    logic [7:0] filled;
    int         nfill;
    int         idle;
    logic [7:0] word;
    logic       done;
    logic       dup;
    logic       to;
  } mdl_t;

  mdl_t ma, mb;
  logic [26:0] exp_a[$];
  logic [26:0] exp_b[$];

  function automatic mdl_t model_step(mdl_t m, bit in_order, int tmo,
                                      logic v, logic [2:0] s, logic b, logic r);
    bit reject;
    m.done = 1'b0;
    m.dup  = 1'b0;
    m.to   = 1'b0;
    if (r) begin
      m = '0;
      return m;
    end
    if (v) begin
      m.idle = 0;
      reject = in_order ? (int'(s) != m.nfill) : (m.filled[s] == 1'b1);
      if (reject) begin
        m.dup = 1'b1;
        if (in_order) begin
          m.filled = '0;
          m.nfill  = 0;
        end
      end else begin
        m.bits[s]   = b;
        m.filled[s] = 1'b1;
        m.nfill     = m.nfill + 1;
        if (m.nfill == 8) begin
          m.word   = m.bits;
          m.done   = 1'b1;
          m.filled = '0;
          m.nfill  = 0;
        end
      end
    end else if (m.nfill > 0) begin
      m.idle = m.idle + 1;
      if (m.idle == tmo) begin
        m.to     = 1'b1;
        m.filled = '0;
        m.nfill  = 0;
        m.idle   = 0;
      end
    end
    return m;
  endfunction

  function automatic logic [26:0] snap(mdl_t m);
    return {m.bits, m.filled, m.word, m.done, m.dup, m.to};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [2:0] s, input logic b, input logic r);
    valid = v;
    sel   = s;
    in    = b;
    rst   = r;
    @(posedge clk);
    ma = model_step(ma, 1'b0, 4, v, s, b, r);
    mb = model_step(mb, 1'b1, 16, v, s, b, r);
    exp_a.push_back(snap(ma));
    exp_b.push_back(snap(mb));
    #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 3'bxxx, 1'bx, 1'b0);
  endtask

  task automatic sweep(input logic [7:0] w);
    for (int i = 0; i < 8; i++) drive(1'b1, 3'(i), w[i], 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (exp_a.size() > 0)
      check("a_outputs", 32'({out_a, written_a, word_a, done_a, dup_a, to_a}),
            32'(exp_a.pop_front()));
    if (exp_b.size() > 0)
      check("b_outputs", 32'({out_b, written_b, word_b, done_b, dup_b, to_b}),
            32'(exp_b.pop_front()));
  end

  // ---------------- stimulus ----------------
  logic [7:0] order2 [8];
  logic [7:0] pat;
  int         pulses, last_done, chunk_p;

  initial begin
    ma = '0;
    mb = '0;
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    check("reset_out", 32'(out_a), 32'h0);
    check("reset_written", 32'(written_a), 32'h0);
    check("reset_pulses", 32'({done_a, dup_a, to_a, done_b, dup_b, to_b}), 32'h0);
    check("reset_state", 32'(st_a), 32'h0);

    // 1: in-order sweep of D5
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    pat = 8'b11010101;
    for (int i = 0; i < 7; i++) drive(1'b1, 3'(i), pat[i], 1'b0);
    check("t1_fill_state", 32'(st_a), 32'h1);
    check("t1_no_done_early", 32'(done_a), 32'h0);
    drive(1'b1, 3'd7, pat[7], 1'b0);
    check("t1_done", 32'(done_a), 32'h1);
    check("t1_word", 32'(word_a), 32'hD5);
    check("t1_written", 32'(written_a), 32'h0);
    idle_cycle();
    check("t1_done_drop", 32'(done_a), 32'h0);

    // 2: scattered order from A3, clean then with a duplicate sel=3
    order2 = '{8'd7, 8'd0, 8'd3, 8'd5, 8'd1, 8'd6, 8'd2, 8'd4};
    pat = 8'hA3;
    for (int i = 0; i < 8; i++) drive(1'b1, 3'(order2[i]), pat[order2[i]], 1'b0);
    check("t2_word", 32'(word_a), 32'hA3);
    check("t2_done", 32'(done_a), 32'h1);
    for (int i = 0; i < 4; i++) drive(1'b1, 3'(order2[i]), ~pat[order2[i]], 1'b0);
    drive(1'b1, 3'd3, pat[3], 1'b0);
    check("t2_dup", 32'(dup_a), 32'h1);
    check("t2_dup_written", 32'(written_a), 32'hA9);
    for (int i = 4; i < 8; i++) drive(1'b1, 3'(order2[i]), ~pat[order2[i]], 1'b0);
    check("t2_dup_word", 32'(word_a), 32'h5C);
    check("t2_dup_nodup", 32'(dup_a), 32'h0);

    // 3: strict order on dut_b
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    drive(1'b1, 3'd0, 1'b1, 1'b0);
    drive(1'b1, 3'd1, 1'b1, 1'b0);
    drive(1'b1, 3'd3, 1'b1, 1'b0);
    check("t3_order_err", 32'(dup_b), 32'h1);
    check("t3_order_written", 32'(written_b), 32'h0);
    sweep(8'h5A);
    check("t3_word", 32'(word_b), 32'h5A);

    // 4: timeout with TIMEOUT=4 on dut_a
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    drive(1'b1, 3'd0, 1'b1, 1'b0);
    drive(1'b1, 3'd1, 1'b1, 1'b0);
    check("t4_written", 32'(written_a), 32'h03);
    for (int i = 0; i < 3; i++) idle_cycle();
    check("t4_no_to_early", 32'(to_a), 32'h0);
    idle_cycle();
    check("t4_timeout", 32'(to_a), 32'h1);
    check("t4_written_clr", 32'(written_a), 32'h0);
    check("t4_out_kept", 32'(out_a[1:0]), 32'h3);
    drive(1'b1, 3'd0, 1'b0, 1'b0);
    drive(1'b1, 3'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle_cycle();
    drive(1'b1, 3'd2, 1'b1, 1'b0);
    check("t4_rescued", 32'({to_a, written_a}), 32'h007);

    // 5: reset mid-frame
    for (int i = 0; i < 5; i++) drive(1'b1, 3'(i), 1'b1, 1'b0);
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    check("t5_reset_all", 32'({out_a, written_a, word_a, done_a, dup_a, to_a}), 32'h0);
    sweep(8'h3C);
    check("t5_word", 32'(word_a), 32'h3C);

    // 6: back-to-back frames
    pulses = 0;
    last_done = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 3'(i % 8), (i < 8), 1'b0);
      if (done_a) begin
        pulses++;
        if (pulses == 1) check("t6_word_ff", 32'(word_a), 32'hFF);
        if (pulses == 2) begin
          check("t6_word_00", 32'(word_a), 32'h00);
          check("t6_spacing", 32'(i - last_done), 32'd8);
        end
        last_done = i;
      end
    end
    check("t6_pulses", 32'(pulses), 32'd2);

    // random phase: bursts with varying density, strict-order bias for dut_b
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    for (int c = 0; c < 60; c++) begin
      chunk_p = $urandom_range(0, 3) * 33;
      for (int k = 0; k < 20; k++) begin
        if ($urandom_range(0, 199) == 0) drive(1'b0, 3'd0, 1'b0, 1'b1);
        else if ($urandom_range(1, 100) <= chunk_p) begin
          if ($urandom_range(0, 1) == 1) drive(1'b1, 3'(mb.nfill), 1'($urandom), 1'b0);
          else drive(1'b1, 3'($urandom_range(0, 7)), 1'($urandom), 1'b0);
        end else idle_cycle();
      end
    end

    idle_cycle();
    @(negedge clk);
    #1;
    check("queues_drained", 32'(exp_a.size() + exp_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
